// File: rtl/vga_timing_checker.sv
// vga_timing_checker
//   Reference checker for a 640x480-style VGA timing generator. After reset it
//   waits START_DELAY clkin cycles, then runs its own pixel/line counters and
//   compares the DUT's HS/VS against ideal sync. It also flags any non-black
//   RGB outside the active window. Mismatches are counted in saturating
//   counters, and completed frames are counted modulo 2^16.
//
//   Optional build macro: VGA_CHK_FIRST_ERR_EN
//     When defined, the checker adds first_err_valid/first_err_h/first_err_v.
//     These latch the h/v position of the first sync or RGB error after reset.
//
// Ports
//   clkin                      single clock, rising edge
//   greset                     synchronous active-high reset
//   myHS, myVS                 sync outputs of the design under observation
//   vgaRed/Green/Blue [3:0]    colour outputs of the design under observation
//   good_HS, good_VS           expected syncs (registered)
//   activeH, activeV           expected active windows (registered)
//   sync_error, rgb_error      combinational mismatch flags
//   hs_err_cnt, vs_err_cnt,
//   rgb_err_cnt [CNT_W-1:0]    saturating error counters
//   frame_cnt [15:0]           completed frames, wraps
//   running                    comparison enabled
module vga_timing_checker #(
  parameter int unsigned PIX_DIV     = 4,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 15,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 49,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 9,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 34,
  parameter logic        SYNC_POL    = 1'b0,
  parameter int unsigned START_DELAY = 158,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned H_W        = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int unsigned V_W        = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
  input  logic             clkin,
  input  logic             greset,
  input  logic             myHS,
  input  logic             myVS,
  input  logic [3:0]       vgaRed,
  input  logic [3:0]       vgaGreen,
  input  logic [3:0]       vgaBlue,
  output logic             good_HS,
  output logic             good_VS,
  output logic             activeH,
  output logic             activeV,
  output logic             sync_error,
  output logic             rgb_error,
  output logic [CNT_W-1:0] hs_err_cnt,
  output logic [CNT_W-1:0] vs_err_cnt,
  output logic [CNT_W-1:0] rgb_err_cnt,
  output logic [15:0]      frame_cnt,
  output logic             running
`ifdef VGA_CHK_FIRST_ERR_EN
  ,
  output logic             first_err_valid,
  output logic [H_W-1:0]   first_err_h,
  output logic [V_W-1:0]   first_err_v
`endif
);

  localparam int unsigned P_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned D_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [P_W-1:0] PRE_LAST = P_W'(PIX_DIV - 1);
  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [D_W-1:0] DLY_LAST = D_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t         state, state_nxt;
  logic [D_W-1:0] dly_cnt, dly_nxt;
  logic [P_W-1:0] pre, pre_nxt;
  logic [H_W-1:0] h, h_nxt;
  logic [V_W-1:0] v, v_nxt;
  logic           pre_wrap, h_wrap, v_wrap;
  logic           frame_end;
  logic           hs_mis, vs_mis;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkin) begin
    if (greset) begin
      state   <= ST_IDLE;
      dly_cnt <= '0;
    end else begin
      state   <= state_nxt;
      dly_cnt <= dly_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dly_nxt   = '0;
    if (greset) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = (START_DELAY == 0) ? ST_RUN : ST_WAIT;
        ST_WAIT: begin
          if (dly_cnt == DLY_LAST) state_nxt = ST_RUN;
          else                     dly_nxt   = dly_cnt + 1'b1;
        end
        ST_RUN:  state_nxt = ST_RUN;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign running = (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Pixel position: prescaler -> h -> v. All three are held at zero outside
  // RUN, so the first RUN cycle starts at (0,0).
  // ---------------------------------------------------------------------------
  assign pre_wrap  = (pre == PRE_LAST);
  assign h_wrap    = (h == H_LAST);
  assign v_wrap    = (v == V_LAST);
  assign frame_end = running & pre_wrap & h_wrap & v_wrap;

  always_comb begin
    pre_nxt = '0;
    h_nxt   = '0;
    v_nxt   = '0;
    if (running && !greset) begin
      pre_nxt = pre_wrap ? '0 : pre + 1'b1;
      h_nxt   = h;
      v_nxt   = v;
      if (pre_wrap) begin
        h_nxt = h_wrap ? '0 : h + 1'b1;
        if (h_wrap) v_nxt = v_wrap ? '0 : v + 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    pre <= pre_nxt;
    h   <= h_nxt;
    v   <= v_nxt;
  end

  // ---------------------------------------------------------------------------
  // Expected signals. They are decoded from the next position and registered,
  // so the outputs line up with the current h/v without a cycle of lag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkin) begin
    if (state_nxt == ST_RUN) begin
      activeH <= (32'(h_nxt) < H_ACTIVE);
      activeV <= (32'(v_nxt) < V_ACTIVE);
      good_HS <= ((32'(h_nxt) >= HS_BEG) && (32'(h_nxt) < HS_END)) ? SYNC_POL : ~SYNC_POL;
      good_VS <= ((32'(v_nxt) >= VS_BEG) && (32'(v_nxt) < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end else begin
      activeH <= 1'b1;
      activeV <= 1'b1;
      good_HS <= ~SYNC_POL;
      good_VS <= ~SYNC_POL;
    end
  end

  // ---------------------------------------------------------------------------
  // Error detection
  // ---------------------------------------------------------------------------
  assign hs_mis     = running & (myHS ^ good_HS);
  assign vs_mis     = running & (myVS ^ good_VS);
  assign sync_error = hs_mis | vs_mis;
  assign rgb_error  = running & (|{vgaRed, vgaGreen, vgaBlue}) & ~(activeH & activeV);

  // Reset has priority, so an edge that samples greset never adds a count.
  always_ff @(posedge clkin) begin
    if (greset) begin
      hs_err_cnt  <= '0;
      vs_err_cnt  <= '0;
      rgb_err_cnt <= '0;
      frame_cnt   <= '0;
    end else begin
      if (hs_mis && (hs_err_cnt != '1))     hs_err_cnt  <= hs_err_cnt + 1'b1;
      if (vs_mis && (vs_err_cnt != '1))     vs_err_cnt  <= vs_err_cnt + 1'b1;
      if (rgb_error && (rgb_err_cnt != '1)) rgb_err_cnt <= rgb_err_cnt + 1'b1;
      if (frame_end)                        frame_cnt   <= frame_cnt + 1'b1;
    end
  end

`ifdef VGA_CHK_FIRST_ERR_EN
  // ---------------------------------------------------------------------------
  // First-error position capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkin) begin
    if (greset) begin
      first_err_valid <= 1'b0;
      first_err_h     <= '0;
      first_err_v     <= '0;
    end else if (!first_err_valid && (sync_error || rgb_error)) begin
      first_err_valid <= 1'b1;
      first_err_h     <= h;
      first_err_v     <= v;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_checker.sv
// tb_vga_timing_checker
//   Directed bench for vga_timing_checker.
//
//   dut1 uses a small active-low timing:
//     PIX_DIV 2, H 8/2/3/2 (15), V 4/1/2/1 (8), START_DELAY 5, CNT_W 8.
//     That gives 240 clkin cycles per frame.
//   dut2 uses active-high sync:
//     PIX_DIV 1, H 8/1/2/1 (12), V 4/1/1/1 (7), START_DELAY 0, CNT_W 4.
//     That gives 84 clkin cycles per frame.
//
//   Expected positions come from the bench's own cycle count since RUN entry.
module tb_vga_timing_checker;

  localparam int N1  = 5;
  localparam int PD1 = 2;
  localparam int HT1 = 15;
  localparam int VT1 = 8;
  localparam int FC1 = PD1 * HT1 * VT1;

  logic clkin = 1'b0;
  always #5 clkin = ~clkin;

  // dut1 signals
  logic       greset1, myHS1, myVS1;
  logic [3:0] red1, grn1, blu1;
  logic       good_HS1, good_VS1, activeH1, activeV1, sync_error1, rgb_error1, running1;
  logic [7:0] hs_cnt1, vs_cnt1, rgb_cnt1;
  logic [15:0] frm1;

  // dut2 signals
  logic       greset2, myHS2, myVS2;
  logic [3:0] red2, grn2, blu2;
  logic       good_HS2, good_VS2, activeH2, activeV2, sync_error2, rgb_error2, running2;
  logic [3:0] hs_cnt2, vs_cnt2, rgb_cnt2;
  logic [15:0] frm2;

`ifdef VGA_CHK_FIRST_ERR_EN
  logic       fe_valid1, fe_valid2;
  logic [3:0] fe_h1, fe_h2;
  logic [2:0] fe_v1, fe_v2;
`endif

  vga_timing_checker #(
    .PIX_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .START_DELAY(5), .CNT_W(8)
  ) dut1 (
    .clkin(clkin), .greset(greset1), .myHS(myHS1), .myVS(myVS1),
    .vgaRed(red1), .vgaGreen(grn1), .vgaBlue(blu1),
    .good_HS(good_HS1), .good_VS(good_VS1), .activeH(activeH1), .activeV(activeV1),
    .sync_error(sync_error1), .rgb_error(rgb_error1),
    .hs_err_cnt(hs_cnt1), .vs_err_cnt(vs_cnt1), .rgb_err_cnt(rgb_cnt1),
    .frame_cnt(frm1), .running(running1)
`ifdef VGA_CHK_FIRST_ERR_EN
    , .first_err_valid(fe_valid1), .first_err_h(fe_h1), .first_err_v(fe_v1)
`endif
  );

  vga_timing_checker #(
    .PIX_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .START_DELAY(0), .CNT_W(4)
  ) dut2 (
    .clkin(clkin), .greset(greset2), .myHS(myHS2), .myVS(myVS2),
    .vgaRed(red2), .vgaGreen(grn2), .vgaBlue(blu2),
    .good_HS(good_HS2), .good_VS(good_VS2), .activeH(activeH2), .activeV(activeV2),
    .sync_error(sync_error2), .rgb_error(rgb_error2),
    .hs_err_cnt(hs_cnt2), .vs_err_cnt(vs_cnt2), .rgb_err_cnt(rgb_cnt2),
    .frame_cnt(frm2), .running(running2)
`ifdef VGA_CHK_FIRST_ERR_EN
    , .first_err_valid(fe_valid2), .first_err_h(fe_h2), .first_err_v(fe_v2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int trk_bad;
  int trk_first;

  // Stimulus modes, applied in frame 0 only:
  //   hm 1: HS asserted one pixel early on every line.
  //   vm 1: VS wrong at that same pixel on line 0.
  //   rm 1: red=F for 10 cycles from h=9, v=0.
  //   rm 2: colour on line 4 (vertical blank) over h 0..7.
  typedef struct {
    int hm, vm, rm, frames;
    int ehs, evs, ergb, efrm;
    int efh, efv;
  } vec_t;

  vec_t  vecs[6];
  string vname[6];

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic void model(input int t, input int pd, input int ht, input int vt,
                                output int h, output int v, output int fr);
    int pix;
    pix = t / pd;
    h   = pix % ht;
    v   = (pix / ht) % vt;
    fr  = pix / (ht * vt);
  endfunction

  // One dut1 cycle at k edges after greset was first sampled low.
  task automatic cyc1(input int k, input int hm, input int vm, input int rm);
    int t, h, v, fr;
    logic ehs, evs, eah, eav, erun, hs_i, vs_i, esync, ergb;
    logic [11:0] col;
    tick();
    if (k < N1) begin
      erun = 0; ehs = 1; evs = 1; eah = 1; eav = 1;
      hs_i = 1; vs_i = 1; col = '0;
    end else begin
      t = k - N1;
      model(t, PD1, HT1, VT1, h, v, fr);
      erun = 1;
      ehs  = !(h >= 10 && h < 13);
      evs  = !(v >= 5 && v < 7);
      eah  = (h < 8);
      eav  = (v < 4);
      hs_i = ehs;
      vs_i = evs;
      col  = (eah && eav) ? 12'hA5C : 12'h000;
      if (fr == 0) begin
        if (hm == 1 && h == 9)            hs_i = 1'b0;
        if (vm == 1 && v == 0 && h == 9)  vs_i = ~evs;
        if (rm == 1 && t >= 18 && t < 28) col[11:8] = 4'hF;
        if (rm == 2 && v == 4 && h < 8)   col = 12'h100;
      end
    end
    myHS1 = hs_i; myVS1 = vs_i;
    {red1, grn1, blu1} = col;
    #1;
    esync = erun & ((hs_i ^ ehs) | (vs_i ^ evs));
    ergb  = erun & (col != 12'h000) & ~(eah & eav);
    if ({good_HS1, good_VS1, activeH1, activeV1, running1, sync_error1, rgb_error1} !==
        {ehs, evs, eah, eav, erun, esync, ergb}) begin
      trk_bad++;
      if (trk_first < 0) trk_first = k;
    end
  endtask

  // One dut2 cycle. START_DELAY is 0, so k is also the RUN time.
  task automatic cyc2(input int k, input bit vinv);
    int h, v, fr;
    logic ehs, evs, eah, eav, vs_i, esync, ergb;
    logic [11:0] col;
    tick();
    model(k, 1, 12, 7, h, v, fr);
    ehs  = (h >= 9 && h < 11);
    evs  = (v == 5);
    eah  = (h < 8);
    eav  = (v < 4);
    vs_i = vinv ? ~evs : evs;
    col  = (eah && eav) ? 12'h3C7 : 12'h000;
    myHS2 = ehs; myVS2 = vs_i;
    {red2, grn2, blu2} = col;
    #1;
    esync = vs_i ^ evs;
    ergb  = 1'b0;
    if ({good_HS2, good_VS2, activeH2, activeV2, running2, sync_error2, rgb_error2} !==
        {ehs, evs, eah, eav, 1'b1, esync, ergb}) begin
      trk_bad++;
      if (trk_first < 0) trk_first = k;
    end
  endtask

  task automatic idle1();
    myHS1 = 1; myVS1 = 1; red1 = '0; grn1 = '0; blu1 = '0;
  endtask

  task automatic reset1();
    greset1 = 1;
    idle1();
    repeat (3) tick();
  endtask

  task automatic run_vec(input int i);
    vec_t  tv;
    string nm;
    int    last;
    tv = vecs[i];
    nm = vname[i];
    reset1();
    chk($sformatf("%s_rst", nm),
        {hs_cnt1, vs_cnt1, rgb_cnt1, frm1, running1, good_HS1, good_VS1, activeH1, activeV1},
        {40'd0, 5'b01111});
    greset1 = 0;
    trk_bad = 0; trk_first = -1;
    last = N1 + tv.frames * FC1;
    for (int k = 0; k <= last; k++) cyc1(k, tv.hm, tv.vm, tv.rm);
    chk($sformatf("%s_track(first k=%0d)", nm, trk_first), trk_bad, 0);
    chk($sformatf("%s_hs_cnt", nm),  hs_cnt1,  tv.ehs);
    chk($sformatf("%s_vs_cnt", nm),  vs_cnt1,  tv.evs);
    chk($sformatf("%s_rgb_cnt", nm), rgb_cnt1, tv.ergb);
    chk($sformatf("%s_frames", nm),  frm1,     tv.efrm);
`ifdef VGA_CHK_FIRST_ERR_EN
    if (tv.efh < 0) begin
      chk($sformatf("%s_fe_valid", nm), fe_valid1, 0);
    end else begin
      chk($sformatf("%s_fe_valid", nm), fe_valid1, 1);
      chk($sformatf("%s_fe_h", nm), fe_h1, tv.efh);
      chk($sformatf("%s_fe_v", nm), fe_v1, tv.efv);
    end
`endif
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 2,  0, 0,  0, 2, -1, -1}; vname[0] = "ideal";
    vecs[1] = '{1, 0, 0, 2, 16, 0,  0, 2,  9,  0}; vname[1] = "hs_early";
    vecs[2] = '{1, 1, 0, 2, 16, 2,  0, 2,  9,  0}; vname[2] = "hs_vs";
    vecs[3] = '{0, 0, 1, 1,  0, 0, 10, 1,  9,  0}; vname[3] = "rgb_hblank";
    vecs[4] = '{0, 0, 2, 2,  0, 0, 16, 2,  0,  4}; vname[4] = "rgb_vblank";
    vecs[5] = '{1, 1, 1, 2, 16, 2, 10, 2,  9,  0}; vname[5] = "all_errs";

    greset1 = 1; greset2 = 1;
    idle1();
    myHS2 = 0; myVS2 = 0; red2 = '0; grn2 = '0; blu2 = '0;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Mid-frame reset after errors, then restart latency.
    reset1();
    greset1 = 0;
    trk_bad = 0; trk_first = -1;
    for (int k = 0; k <= N1 + 300; k++) cyc1(k, 1, 1, 1);
    chk("pre_rst_hs",  hs_cnt1,  16);
    chk("pre_rst_vs",  vs_cnt1,  2);
    chk("pre_rst_rgb", rgb_cnt1, 10);
    chk("pre_rst_frm", frm1,     1);
    // HS is driven wrong on the reset edge itself; nothing may be counted.
    greset1 = 1;
    myHS1 = 0; red1 = 4'hF;
    tick();
    chk("mid_rst_state",
        {hs_cnt1, vs_cnt1, rgb_cnt1, frm1, running1, good_HS1, good_VS1, activeH1, activeV1},
        {40'd0, 5'b01111});
    idle1();
    repeat (2) tick();
    greset1 = 0;
    for (int k = 0; k <= N1; k++) begin
      cyc1(k, 0, 0, 0);
      if (k == N1 - 1) chk("restart_not_yet", running1, 0);
      if (k == N1)     chk("restart_running", running1, 1);
    end
    chk($sformatf("restart_track(first k=%0d)", trk_first), trk_bad, 0);
    greset1 = 1;
    tick();

    // dut2: active-high sync, PIX_DIV 1, zero start delay, 4-bit counters.
    chk("d2_rst",
        {hs_cnt2, vs_cnt2, rgb_cnt2, frm2, running2, good_HS2, good_VS2, activeH2, activeV2},
        {28'd0, 5'b00011});
    greset2 = 0;
    trk_bad = 0; trk_first = -1;
    for (int k = 0; k <= 168; k++) begin
      cyc2(k, 1'b0);
      if (k == 83)  chk("d2_frm_at83", frm2, 0);
      if (k == 84)  chk("d2_frm_at84", frm2, 1);
      if (k == 167) chk("d2_frm_at167", frm2, 1);
      if (k == 168) chk("d2_frm_at168", frm2, 2);
    end
    chk("d2_hs_cnt",  hs_cnt2,  0);
    chk("d2_vs_cnt",  vs_cnt2,  0);
    chk("d2_rgb_cnt", rgb_cnt2, 0);
    for (int k = 169; k <= 209; k++) begin
      cyc2(k, 1'b1);
      if (k == 179) chk("d2_vs_cnt_10", vs_cnt2, 10);
    end
    chk("d2_vs_sat", vs_cnt2, 15);
    chk("d2_hs_sat_run", hs_cnt2, 0);
    chk($sformatf("d2_track(first k=%0d)", trk_first), trk_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
